load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 184 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I load/store unit with alignment/range checks and
//            read-modify-write merging for byte and halfword stores.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_cause,
  output logic        mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  MERGE = 2'd1;
  localparam logic [1:0]  RESP  = 2'd2;

  localparam logic [30:0] c_DEPTH = 31'(DEPTH_WORDS);

  localparam logic [1:0]  c_OK       = 2'b00;
  localparam logic [1:0]  c_MISALIGN = 2'b01;
  localparam logic [1:0]  c_RANGE    = 2'b10;
  localparam logic [1:0]  c_ILLEGAL  = 2'b11;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_is_half;
  logic [31:0] r_rdata;
  logic [1:0]  r_cause;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_range;
  logic [1:0]  w_cause;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic        w_sw_now;

  assign req_ready = rst_n && (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  // Request classification, evaluated straight off the request bus.
  always_comb begin
    w_illegal = 1'b0;
    if (req_we) begin
      w_illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
    end else begin
      w_illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010 ||
                    req_funct3 == 3'b100 || req_funct3 == 3'b101);
    end
  end

  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_range    = {1'b0, req_addr[31:2]} >= c_DEPTH;

  always_comb begin
    w_cause = c_OK;
    if (w_illegal) begin
      w_cause = c_ILLEGAL;
    end else if (w_misalign) begin
      w_cause = c_MISALIGN;
    end else if (w_range) begin
      w_cause = c_RANGE;
    end
  end

  always_comb begin
    w_byte = mem_r_data[7:0];
    case (req_addr[1:0])
      2'd0:    w_byte = mem_r_data[7:0];
      2'd1:    w_byte = mem_r_data[15:8];
      2'd2:    w_byte = mem_r_data[23:16];
      default: w_byte = mem_r_data[31:24];
    endcase
  end

  assign w_half = req_addr[1] ? mem_r_data[31:16] : mem_r_data[15:0];

  always_comb begin
    w_load = 32'd0;
    case (req_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = mem_r_data;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
  end

  // Only the addressed lanes of the current word are replaced.
  always_comb begin
    w_merge = mem_r_data;
    if (r_is_half) begin
      if (r_addr[1]) begin
        w_merge[31:16] = r_wdata;
      end else begin
        w_merge[15:0]  = r_wdata;
      end
    end else begin
      case (r_addr[1:0])
        2'd0:    w_merge[7:0]   = r_wdata[7:0];
        2'd1:    w_merge[15:8]  = r_wdata[7:0];
        2'd2:    w_merge[23:16] = r_wdata[7:0];
        default: w_merge[31:24] = r_wdata[7:0];
      endcase
    end
  end

  assign w_sw_now   = w_accept && req_we && (w_cause == c_OK) && (req_funct3 == 3'b010);
  assign mem_w_en   = rst_n && (w_sw_now || (r_state == MERGE));
  assign mem_addr   = (r_state == MERGE) ? {2'b00, r_addr[31:2]} : {2'b00, req_addr[31:2]};
  assign mem_w_data = (r_state == MERGE) ? w_merge : req_wdata;

  assign rsp_valid  = (r_state == RESP);
  assign rsp_rdata  = r_rdata;
  assign rsp_cause  = r_cause;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= 32'd0;
      r_wdata   <= 16'd0;
      r_is_half <= 1'b0;
      r_rdata   <= 32'd0;
      r_cause   <= c_OK;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cause <= w_cause;
            r_rdata <= 32'd0;
            r_state <= RESP;
            if (w_cause == c_OK) begin
              if (!req_we) begin
                r_rdata <= w_load;
              end else if (req_funct3 != 3'b010) begin
                r_addr    <= req_addr;
                r_wdata   <= req_wdata[15:0];
                r_is_half <= req_funct3[0];
                r_state   <= MERGE;
              end
            end
          end
        end
        MERGE: begin
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench for load_store_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_cause;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  logic [31:0] mem [0:31];
  int          wr_count = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          wr_snap;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_WORDS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_cause  (rsp_cause),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
  );

  assign mem_r_data = (mem_addr < 32'd32) ? mem[mem_addr[4:0]] : 32'd0;

  always @(posedge clk) begin
    if (mem_w_en) begin
      if (mem_addr < 32'd32) mem[mem_addr[4:0]] <= mem_w_data;
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
  endtask

  // Called at a negedge while the unit sits in RESP: take the response.
  task automatic handoff();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
  endtask

  // One-cycle load or error request, response checked a cycle later.
  task automatic single(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_cause);
    @(negedge clk);
    drive(we, f3, addr, 32'hDEAD_BEEF);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_wen_acc"}, {31'd0, mem_w_en}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, exp_data);
    chk({tag, "_cause"}, {30'd0, rsp_cause}, {30'd0, exp_cause});
    chk({tag, "_wen_resp"}, {31'd0, mem_w_en}, 32'd0);
    handoff();
    chk({tag, "_idle"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[3] = 32'h8081_F2F3;
    mem[5] = 32'h1122_3344;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_wen", {31'd0, mem_w_en}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_cause", {30'd0, rsp_cause}, 32'd0);
    chk("rst_ready_rel", {31'd0, req_ready}, 32'd1);

    // Loads with sign / zero extension
    single("lb_0d",  1'b0, 3'b000, 32'h0000_000D, 32'hFFFF_FFF2, 2'b00);
    single("lhu_0e", 1'b0, 3'b101, 32'h0000_000E, 32'h0000_8081, 2'b00);
    single("lh_0e",  1'b0, 3'b001, 32'h0000_000E, 32'hFFFF_8081, 2'b00);
    single("lbu_0f", 1'b0, 3'b100, 32'h0000_000F, 32'h0000_0080, 2'b00);

    // Byte store through the merge path
    wr_snap = wr_count;
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h0000_0015, 32'h0000_00AB);
    chk("sb_wen_acc", {31'd0, mem_w_en}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("sb_wen_merge", {31'd0, mem_w_en}, 32'd1);
    chk("sb_wdata", mem_w_data, 32'h1122_AB44);
    chk("sb_merge_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("sb_wen_resp", {31'd0, mem_w_en}, 32'd0);
    chk("sb_word5", mem[5], 32'h1122_AB44);
    chk("sb_writes", wr_count - wr_snap, 32'd1);
    chk("sb_cause", {30'd0, rsp_cause}, 32'd0);
    chk("sb_rdata", rsp_rdata, 32'd0);
    handoff();

    // Word store, written in the acceptance cycle
    wr_snap = wr_count;
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h0000_0018, 32'hCAFE_F00D);
    chk("sw_wen_acc", {31'd0, mem_w_en}, 32'd1);
    chk("sw_wdata", mem_w_data, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("sw_word6", mem[6], 32'hCAFE_F00D);
    chk("sw_writes", wr_count - wr_snap, 32'd1);
    chk("sw_cause", {30'd0, rsp_cause}, 32'd0);
    handoff();

    // Error classification
    wr_snap = wr_count;
    single("sw_mis",  1'b1, 3'b010, 32'h0000_0002, 32'd0, 2'b01);
    single("ld_ill",  1'b0, 3'b011, 32'h0000_0004, 32'd0, 2'b11);
    single("lw_oor",  1'b0, 3'b010, 32'h0000_0080, 32'd0, 2'b10);
    single("ill_mis", 1'b1, 3'b100, 32'h0000_0001, 32'd0, 2'b11);
    single("lh_mis",  1'b0, 3'b001, 32'h0000_0081, 32'd0, 2'b01);
    chk("err_no_writes", wr_count - wr_snap, 32'd0);

    // Back-pressure on the response
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h0000_000C, 32'd0);
    @(negedge clk);
    drive(1'b0, 3'b010, 32'h0000_0014, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h8081_F2F3);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      #1;
    end
    chk("bp_valid_last", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp_handoff_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_handoff_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("bp_next_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_next_rdata", rsp_rdata, 32'h1122_AB44);
    handoff();

    // Reset while a halfword store is merging
    wr_snap = wr_count;
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h0000_0016, 32'h0000_BEEF);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rm_wen", {31'd0, mem_w_en}, 32'd0);
    chk("rm_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rm_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rm_word5", mem[5], 32'h1122_AB44);
    chk("rm_writes", wr_count - wr_snap, 32'd0);

    // Halfword store completes normally after reset
    @(negedge clk);
    drive(1'b1, 3'b001, 32'h0000_0016, 32'h0000_BEEF);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("sh_word5", mem[5], 32'hBEEF_AB44);
    chk("sh_valid", {31'd0, rsp_valid}, 32'd1);
    handoff();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
